// File: rtl/uart_pkg.sv
// Shared definitions for the uart_txrx receiver and transmitter.
// - uart_state_e : state encoding used by both FSMs
// - calc_cpb()   : clk cycles per serial bit, integer division
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned calc_cpb(input int unsigned clk_mhz,
                                           input int unsigned bit_rate);
    return (clk_mhz * 32'd1_000_000) / bit_rate;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver. Samples uart line through a 2-flop synchronizer,
// qualifies the start bit at mid-bit, samples data once per bit period at
// the bit centre and delivers the byte with a one-cycle valid pulse.
// Ports:
//   clk, rstn     : clock, async active-low reset
//   rxd_i         : serial input (asynchronous, idle high)
//   rx_en_i       : receiver enable, low forces IDLE
//   rx_valid_o    : one-cycle pulse, rx_data_o updated
//   rx_break_o    : one-cycle pulse with valid when byte is all zeros
//   rx_data_o     : last received byte
//
// state | meaning
// IDLE  | waiting for a low on the synchronized line
// START | counting to mid start bit, then re-checking the line
// DATA  | sampling PAYLOAD_BITS bits, one per bit period
// STOP  | waiting to mid stop bit, then delivering the byte
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_MHZ      = 50,
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    rxd_i,
  input  logic                    rx_en_i,
  output logic                    rx_valid_o,
  output logic                    rx_break_o,
  output logic [PAYLOAD_BITS-1:0] rx_data_o
);

  localparam int unsigned CPB   = calc_cpb(CLK_MHZ, BIT_RATE);
  localparam int          CNT_W = $clog2(CPB + 1);
  localparam int          IDX_W = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);

  logic                    rxd_s1_q, rxd_s2_q;
  uart_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    break_q, break_d;
  logic                    bit_done;

  assign bit_done = (cnt_q == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      break_q  <= 1'b0;
    end else begin
      rxd_s1_q <= rxd_i;
      rxd_s2_q <= rxd_s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      break_q  <= break_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    break_d = 1'b0;
    if (!rx_en_i) begin
      // Disabling mid-frame drops the partial byte.
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rxd_s2_q) begin
            state_d = START;
            cnt_d   = CNT_HALF;
          end
        end
        START: begin
          if (bit_done) begin
            // Line went back high before mid start bit: treat as glitch.
            state_d = rxd_s2_q ? IDLE : DATA;
            cnt_d   = rxd_s2_q ? '0 : CNT_FULL;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            shreg_d = {rxd_s2_q, shreg_q[PAYLOAD_BITS-1:1]};
            cnt_d   = CNT_FULL;
            if (idx_q == IDX_LAST) begin
              state_d = STOP;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            // Stop-bit level is deliberately not checked.
            state_d = IDLE;
            data_d  = shreg_q;
            valid_d = 1'b1;
            break_d = (shreg_q == '0);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_valid_o = valid_q;
  assign rx_break_o = break_q;
  assign rx_data_o  = data_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter. Accepts a byte in IDLE when tx_en_i is high and
// shifts out start, data (LSB first) and stop bits, each held CPB cycles.
// Ports:
//   clk, rstn  : clock, async active-low reset
//   tx_en_i    : transmit request, only looked at in IDLE
//   tx_data_i  : byte captured on acceptance
//   txd_o      : registered serial output, idle high
//   tx_busy_o  : high from the cycle after acceptance to end of stop bit(s)
//
// state | meaning
// IDLE  | line high, waiting for tx_en_i
// START | driving the start bit
// DATA  | driving PAYLOAD_BITS data bits, LSB first
// STOP  | driving STOP_BITS stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_MHZ      = 50,
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    tx_en_i,
  input  logic [PAYLOAD_BITS-1:0] tx_data_i,
  output logic                    txd_o,
  output logic                    tx_busy_o
);

  localparam int unsigned CPB   = calc_cpb(CLK_MHZ, BIT_RATE);
  localparam int          CNT_W = $clog2(CPB + 1);
  localparam int          IDX_W = $clog2(PAYLOAD_BITS + STOP_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  uart_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
  logic                    txd_q, txd_d;
  logic                    bit_done;

  assign bit_done = (cnt_q == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (tx_en_i) begin
          state_d = START;
          shreg_d = tx_data_i;
          txd_d   = 1'b0;
          cnt_d   = CNT_FULL;
          idx_d   = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = CNT_FULL;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = CNT_FULL;
          if (idx_q == DATA_LAST) begin
            state_d = STOP;
            txd_d   = 1'b1;
            idx_d   = '0;
          end else begin
            txd_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          // Counter is left at zero on return to IDLE.
          if (idx_q == STOP_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            cnt_d = CNT_FULL;
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign txd_o     = txd_q;
  assign tx_busy_o = (state_q != IDLE);

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART top: wires an independent receiver and transmitter
// to shared clock, reset and baud configuration.
// Ports:
//   clk, rstn                  : clock, async active-low reset
//   uart_rxd, uart_rx_en       : serial in, receiver enable
//   uart_rx_valid/_break/_data : received byte interface
//   uart_txd                   : serial out
//   uart_tx_en/_busy/_data     : transmit request interface
module uart_txrx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_MHZ      = 50,
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_break,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_txd,
  input  logic                    uart_tx_en,
  output logic                    uart_tx_busy,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  uart_rx #(
    .CLK_MHZ     (CLK_MHZ),
    .BIT_RATE    (BIT_RATE),
    .PAYLOAD_BITS(PAYLOAD_BITS)
  ) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rxd_i     (uart_rxd),
    .rx_en_i   (uart_rx_en),
    .rx_valid_o(uart_rx_valid),
    .rx_break_o(uart_rx_break),
    .rx_data_o (uart_rx_data)
  );

  uart_tx #(
    .CLK_MHZ     (CLK_MHZ),
    .BIT_RATE    (BIT_RATE),
    .PAYLOAD_BITS(PAYLOAD_BITS),
    .STOP_BITS   (STOP_BITS)
  ) u_tx (
    .clk      (clk),
    .rstn     (rstn),
    .tx_en_i  (uart_tx_en),
    .tx_data_i(uart_tx_data),
    .txd_o    (uart_txd),
    .tx_busy_o(uart_tx_busy)
  );

endmodule

// File: tb/tb_uart_txrx.sv
// Directed self-checking bench for uart_txrx at default parameters
// (50 MHz, 115200 bit/s -> 434 clk per bit).
module tb_uart_txrx;
  import uart_pkg::*;

  localparam int CPB = 434;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rxd_drv;
  logic       loop;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic       uart_rx_valid;
  logic       uart_rx_break;
  logic [7:0] uart_rx_data;
  logic       uart_txd;
  logic       uart_tx_en;
  logic       uart_tx_busy;
  logic [7:0] uart_tx_data;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  assign uart_rxd = loop ? uart_txd : rxd_drv;

  uart_txrx dut (
    .clk          (clk),
    .rstn         (rstn),
    .uart_rxd     (uart_rxd),
    .uart_rx_en   (uart_rx_en),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_break(uart_rx_break),
    .uart_rx_data (uart_rx_data),
    .uart_txd     (uart_txd),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_busy (uart_tx_busy),
    .uart_tx_data (uart_tx_data)
  );

  // Passive monitor on the falling edge: records delivered bytes and
  // transmitter start events.
  int         rx_cnt = 0;
  logic [7:0] rx_d[$];
  logic       rx_b[$];
  int         brk_orphan = 0;
  int         tx_starts = 0;
  int         cyc = 0;
  int         last_rise = 0;
  int         rise_gap = 0;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (uart_rx_valid === 1'b1) begin
      rx_cnt++;
      rx_d.push_back(uart_rx_data);
      rx_b.push_back(uart_rx_break);
    end
    if (uart_rx_break === 1'b1 && uart_rx_valid !== 1'b1) brk_orphan++;
    if (uart_tx_busy === 1'b1 && busy_prev !== 1'b1) begin
      tx_starts++;
      rise_gap  = cyc - last_rise;
      last_rise = cyc;
    end
    busy_prev = uart_tx_busy;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx_byte(input logic [7:0] b);
    rxd_drv = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      tick(CPB);
    end
    rxd_drv = 1'b1;
    tick(CPB);
  endtask

  initial begin
    logic [9:0] fr;
    int         bad;
    int         busy_hi;
    int         n;
    int         cnt0;
    int         starts0;
    logic       ok;

    rstn         = 1'b0;
    rxd_drv      = 1'b1;
    loop         = 1'b0;
    uart_rx_en   = 1'b1;
    uart_tx_en   = 1'b0;
    uart_tx_data = 8'h00;

    // Reset state
    tick(5);
    check("rst_txd_in_reset", 32'(uart_txd), 32'd1);
    check("rst_busy_in_reset", 32'(uart_tx_busy), 32'd0);
    rstn = 1'b1;
    tick(2);
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_busy", 32'(uart_tx_busy), 32'd0);
    check("rst_rx_valid", 32'(uart_rx_valid), 32'd0);
    check("rst_rx_break", 32'(uart_rx_break), 32'd0);
    check("rst_rx_data", 32'(uart_rx_data), 32'h00);

    // TX 0xA5, single-cycle request: frame 0,1,0,1,0,0,1,0,1,1
    fr           = 10'b1_1010_0101_0;
    uart_tx_data = 8'hA5;
    uart_tx_en   = 1'b1;
    tick(1);
    uart_tx_en   = 1'b0;
    busy_hi      = 0;
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int j = 0; j < CPB; j++) begin
        if (uart_txd !== fr[k]) bad++;
        if (uart_tx_busy === 1'b1) busy_hi++;
        tick(1);
      end
      check($sformatf("tx_a5_bit%0d_wrong_samples", k), 32'(bad), 32'd0);
    end
    check("tx_a5_busy_cycles", 32'(busy_hi), 32'd4340);
    check("tx_a5_busy_after", 32'(uart_tx_busy), 32'd0);
    check("tx_a5_txd_after", 32'(uart_txd), 32'd1);

    // Loopback: 0x3C then 0x00 back-to-back with tx_en held high
    loop = 1'b1;
    tick(5);
    cnt0         = rx_cnt;
    starts0      = tx_starts;
    uart_tx_data = 8'h3C;
    uart_tx_en   = 1'b1;
    tick(1);
    check("lb_first_accept", 32'(uart_tx_busy), 32'd1);
    uart_tx_data = 8'h00;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (uart_tx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("lb_busy_fall_timeout", 32'(ok), 32'd1);
    tick(1);
    check("lb_b2b_restart", 32'(uart_tx_busy), 32'd1);
    uart_tx_en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (rx_cnt - cnt0 >= 2 && uart_tx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("lb_rx_timeout", 32'(ok), 32'd1);
    tick(20);
    check("lb_rx_count", 32'(rx_cnt - cnt0), 32'd2);
    if (rx_cnt - cnt0 >= 2) begin
      check("lb_rx0_data", 32'(rx_d[cnt0]), 32'h3C);
      check("lb_rx0_break", 32'(rx_b[cnt0]), 32'd0);
      check("lb_rx1_data", 32'(rx_d[cnt0 + 1]), 32'h00);
      check("lb_rx1_break", 32'(rx_b[cnt0 + 1]), 32'd1);
    end
    check("lb_tx_starts", 32'(tx_starts - starts0), 32'd2);
    check("lb_b2b_spacing", 32'(rise_gap), 32'd4341);
    check("lb_break_without_valid", 32'(brk_orphan), 32'd0);

    // RX glitch: 100 cycles low, shorter than half a bit
    loop    = 1'b0;
    rxd_drv = 1'b1;
    tick(5);
    cnt0    = rx_cnt;
    rxd_drv = 1'b0;
    tick(50);
    check("glitch_in_start", 32'(dut.u_rx.state_q), 32'(START));
    tick(50);
    rxd_drv = 1'b1;
    tick(1000);
    check("glitch_no_valid", 32'(rx_cnt - cnt0), 32'd0);
    check("glitch_back_idle", 32'(dut.u_rx.state_q), 32'(IDLE));

    // Receiver disabled for a whole frame
    uart_rx_en = 1'b0;
    cnt0       = rx_cnt;
    send_rx_byte(8'h81);
    tick(500);
    check("rxdis_no_valid", 32'(rx_cnt - cnt0), 32'd0);
    check("rxdis_data_held", 32'(uart_rx_data), 32'h00);

    // Re-enabled: direct frame 0x5A
    uart_rx_en = 1'b1;
    tick(5);
    send_rx_byte(8'h5A);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (rx_cnt - cnt0 >= 1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("rx5a_timeout", 32'(ok), 32'd1);
    check("rx5a_count", 32'(rx_cnt - cnt0), 32'd1);
    check("rx5a_data_out", 32'(uart_rx_data), 32'h5A);
    if (rx_cnt - cnt0 >= 1) check("rx5a_break", 32'(rx_b[cnt0]), 32'd0);

    // Reset during TX data bit 4 of 0x0F
    fr           = 10'b1_0000_1111_0;
    uart_tx_data = 8'h0F;
    uart_tx_en   = 1'b1;
    tick(1);
    uart_tx_en   = 1'b0;
    tick(5 * CPB + 200);
    check("midrst_txd_bit4", 32'(uart_txd), 32'(fr[5]));
    check("midrst_busy_before", 32'(uart_tx_busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("midrst_txd", 32'(uart_txd), 32'd1);
    check("midrst_busy", 32'(uart_tx_busy), 32'd0);
    check("midrst_rx_data", 32'(uart_rx_data), 32'h00);
    tick(3);
    rstn = 1'b1;
    tick(3);
    check("postrst_busy", 32'(uart_tx_busy), 32'd0);
    check("postrst_txd", 32'(uart_txd), 32'd1);

    // Next request after reset sends a full frame (checked via loopback)
    loop = 1'b1;
    tick(5);
    cnt0         = rx_cnt;
    starts0      = tx_starts;
    uart_tx_data = 8'h96;
    uart_tx_en   = 1'b1;
    tick(1);
    uart_tx_en   = 1'b0;
    n = 0;
    while (uart_tx_busy === 1'b1 && n < 6000) begin
      n++;
      tick(1);
    end
    check("postrst_busy_cycles", 32'(n), 32'd4340);
    tick(10);
    check("postrst_rx_count", 32'(rx_cnt - cnt0), 32'd1);
    if (rx_cnt - cnt0 >= 1) check("postrst_rx_data", 32'(rx_d[cnt0]), 32'h96);
    check("postrst_tx_starts", 32'(tx_starts - starts0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_txrx.md
Name: uart_txrx

Overview:
- Full-duplex 8N1 UART: an independent receiver and transmitter sharing one clock, reset and baud configuration.
- Sits between a byte-level host interface (valid/enable/busy handshakes) and the serial pins uart_rxd/uart_txd.
- Used by system logic and by simulation models as the serial PHY.

Parameters:
- CLK_MHZ, 50, system clock frequency in MHz.
- BIT_RATE, 115200, serial bit rate in bit/s.
- PAYLOAD_BITS, 8, data bits per frame; LSB is sent first.
- STOP_BITS, 1, stop bits per transmitted frame.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rstn  in  1  reset.
- uart_rxd  in  1  serial input, asynchronous to clk, idle high.
- uart_rx_en  in  1  receiver enable; when low the receiver holds IDLE.
- uart_rx_valid  out  1  one-cycle pulse: uart_rx_data holds a new byte.
- uart_rx_break  out  1  one-cycle pulse together with valid when the received byte is all zeros.
- uart_rx_data  out  PAYLOAD_BITS  last received byte, held until the next frame completes.
- uart_txd  out  1  serial output, idle high.
- uart_tx_en  in  1  transmit request, sampled while busy is low.
- uart_tx_busy  out  1  transmitter is occupied.
- uart_tx_data  in  PAYLOAD_BITS  byte to send, captured when the request is accepted.

Interface: reset rstn, asynchronous, active-low; clock clk.

Behaviour:
- Bit period: CPB = (CLK_MHZ*1_000_000)/BIT_RATE clk cycles, integer division. The default is 434. Bit counters are sized to hold CPB.
- Reset values:
  - txd=1, tx_busy=0.
  - rx_valid=0, rx_break=0, rx_data=0.
  - Both FSMs in IDLE; all counters 0.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is delivered.

RX:
- uart_rxd passes through a 2-flop synchronizer.
- FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized low while rx_en=1.
- In START, the line is re-sampled at CPB/2:
  - if still low, go to DATA with the counter reset;
  - if high (glitch), return to IDLE.
- DATA: sample once per CPB and shift in LSB-first. Go to STOP after PAYLOAD_BITS samples.
- STOP: after CPB cycles, load rx_data and pulse rx_valid for exactly 1 cycle, then return to IDLE.
  - The stop-bit level is not checked; the byte is delivered regardless.
- rx_break = rx_valid AND (received byte == 0).
- rx_en deasserted mid-frame: abort to IDLE, no valid pulse.
- Latency: rx_valid rises within 2 sync cycles + 9.5*CPB + 2 clk of the start-bit falling edge.

TX:
- FSM states: IDLE, START, DATA, STOP.
- In IDLE with tx_en=1: capture tx_data, drive txd=0, and assert busy on the next rising edge.
- tx_busy is high from the cycle after acceptance through the last stop-bit cycle. tx_en is ignored while busy.
- Each bit is held for exactly CPB cycles:
  - start bit 0;
  - PAYLOAD_BITS data bits, LSB first;
  - STOP_BITS bits at level 1.
- Busy falls at the end of the stop bit. If tx_en is high in that IDLE cycle, the next frame starts with no extra idle bit. Back-to-back frames are therefore (2+PAYLOAD_BITS)*CPB (+1) cycles apart.
- txd is registered and glitch-free.
- Simultaneous RX and TX operate fully independently.

Decomposition:
- Shared package uart_pkg holds:
  - CPB computation as a function of CLK_MHZ/BIT_RATE;
  - a state enum {IDLE, START, DATA, STOP} used by both FSMs.
- Natural sub-modules are uart_rx and uart_tx. The top uart_txrx only wires them together.

Test Plan:
- Reset: hold rstn low, release -> txd=1, busy=0, rx_valid=0, rx_data=0.
- TX 0xA5 at defaults, tx_en pulsed 1 cycle -> txd shows 0,1,0,1,0,0,1,0,1,1, each bit held 434 cycles; busy high for 4340 cycles.
- Loopback txd->rxd, send 0x3C then 0x00 with tx_en held high -> two rx_valid pulses: data 0x3C with break=0, then 0x00 with break=1. Exactly two transmissions.
- RX glitch: rxd low for 100 cycles, then high -> no valid pulse, FSM back in IDLE.
- rx_en=0 during a full frame -> no valid; rx_data keeps its previous value.
- Reset mid-TX at bit 4 -> txd=1 and busy=0 immediately; the next request sends a complete frame.
